// File: rtl/imem_loader.sv
// Instruction-memory loader: unpacks a framed byte stream into 32-bit word writes
// and holds the core in reset until a checksum-valid image has been stored.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'd0,
  parameter int unsigned MAX_WORDS      = 256,
  parameter logic [7:0]  START_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam int unsigned TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] MAX_W   = 17'(MAX_WORDS);

  state_t          state;
  logic [15:0]     len;
  logic [1:0]      lane;
  logic [7:0]      csum;
  logic [TW-1:0]   tcnt;
  logic            xfer;
  logic            timed_out;

  assign in_ready  = (state != S_WRITE);
  assign xfer      = in_valid & in_ready;
  assign timed_out = (tcnt == T_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      len          <= '0;
      lane         <= '0;
      csum         <= '0;
      tcnt         <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          tcnt <= '0;
          if (xfer && in_data == START_BYTE) begin
            state        <= S_LEN_LO;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            csum         <= '0;
            lane         <= '0;
            mem_addr     <= BASE_ADDR;
          end
        end

        S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: begin
          if (xfer) begin
            tcnt <= '0;
            case (state)
              S_LEN_LO: begin
                len[7:0] <= in_data;
                state    <= S_LEN_HI;
              end
              S_LEN_HI: begin
                len[15:8] <= in_data;
                if ({1'b0, in_data, len[7:0]} > MAX_W) begin
                  state <= S_ERR;
                  error <= 1'b1;
                end else if ({in_data, len[7:0]} == 16'd0) begin
                  state <= S_CSUM;
                end else begin
                  state <= S_DATA;
                end
              end
              S_DATA: begin
                mem_wdata[{lane, 3'b000} +: 8] <= in_data;
                csum <= csum ^ in_data;
                lane <= lane + 2'd1;
                if (lane == 2'd3) begin
                  state  <= S_WRITE;
                  mem_we <= 1'b1;
                end
              end
              default: begin
                if (in_data == csum) begin
                  state    <= S_DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                end else begin
                  state <= S_ERR;
                  error <= 1'b1;
                end
              end
            endcase
          end else if (timed_out) begin
            state <= S_ERR;
            error <= 1'b1;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_WRITE: begin
          // Address advances only when another word follows, so it never
          // points past the last accepted slot.
          mem_we       <= 1'b0;
          tcnt         <= '0;
          words_loaded <= words_loaded + 16'd1;
          if (words_loaded + 16'd1 == len) begin
            state <= S_CSUM;
          end else begin
            state    <= S_DATA;
            mem_addr <= mem_addr + 32'd4;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
